// File: rtl/mcb_cmd_enc.sv
// SDR SDRAM command encoder with minimum-spacing guard for the MCB back end.
// Init pulses are encoded while in ST_INI; a scheduler stream is accepted in ST_RUN.
module mcb_cmd_enc #(
    parameter int                ADDR_W = 12,
    parameter int                BA_W   = 2,
    parameter logic [ADDR_W-1:0] MR_VAL = 12'h032,
    parameter int                TRP    = 3,
    parameter int                TRFC   = 8,
    parameter int                TMRD   = 2,
    parameter int                TRCD   = 3,
    parameter int                GCNT_W = 4
) (
    input  logic              mcb_clk,
    input  logic              mcb_rst_n,
    input  logic              mcb_sclr_n,
    input  logic              i_prea,
    input  logic              i_ref,
    input  logic              i_lmr,
    input  logic              i_ready,
    input  logic              n_cmd_vld,
    input  logic [2:0]        n_cmd,
    input  logic [ADDR_W-1:0] n_addr,
    input  logic [BA_W-1:0]   n_ba,
    output logic              n_cmd_rdy,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic [BA_W-1:0]   sdr_ba,
    output logic              o_tviol
);

    localparam logic [3:0] PIN_DES = 4'b1111;
    localparam logic [3:0] PIN_NOP = 4'b0111;
    localparam logic [3:0] PIN_ACT = 4'b0011;
    localparam logic [3:0] PIN_RD  = 4'b0101;
    localparam logic [3:0] PIN_WR  = 4'b0100;
    localparam logic [3:0] PIN_PRE = 4'b0010;
    localparam logic [3:0] PIN_REF = 4'b0001;
    localparam logic [3:0] PIN_LMR = 4'b0000;

    typedef enum logic {ST_INI, ST_RUN} state_t;

    state_t            state, state_nxt;
    logic [GCNT_W-1:0] g_cnt, g_cnt_nxt;
    logic [3:0]        pins_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [BA_W-1:0]   ba_nxt;
    logic              tviol_nxt;
    logic              any_pulse;
    logic              multi_pulse;
    logic              accept;

    always_comb begin
        any_pulse   = i_prea | i_ref | i_lmr;
        multi_pulse = (i_prea & i_ref) | (i_prea & i_lmr) | (i_ref & i_lmr);
        n_cmd_rdy   = mcb_sclr_n && (state == ST_RUN) && (g_cnt == '0) && !any_pulse;
        accept      = n_cmd_vld & n_cmd_rdy;

        state_nxt = state;
        pins_nxt  = PIN_NOP;
        addr_nxt  = '0;
        ba_nxt    = '0;
        tviol_nxt = o_tviol;
        g_cnt_nxt = (g_cnt != '0) ? g_cnt - 1'b1 : '0;

        case (state)
            ST_INI: begin
                // Init pulses always issue; overlap or early issue only raises the flag.
                if (any_pulse) begin
                    if (multi_pulse || (g_cnt != '0))
                        tviol_nxt = 1'b1;
                    if (i_prea) begin
                        pins_nxt     = PIN_PRE;
                        addr_nxt[10] = 1'b1;
                        g_cnt_nxt    = GCNT_W'(TRP - 1);
                    end else if (i_ref) begin
                        pins_nxt  = PIN_REF;
                        g_cnt_nxt = GCNT_W'(TRFC - 1);
                    end else begin
                        pins_nxt  = PIN_LMR;
                        addr_nxt  = MR_VAL;
                        g_cnt_nxt = GCNT_W'(TMRD - 1);
                    end
                end
                if (i_ready)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (any_pulse)
                    tviol_nxt = 1'b1;
                if (accept) begin
                    case (n_cmd)
                        3'd1: begin
                            pins_nxt  = PIN_ACT;
                            addr_nxt  = n_addr;
                            ba_nxt    = n_ba;
                            g_cnt_nxt = GCNT_W'(TRCD - 1);
                        end
                        3'd2: begin
                            pins_nxt     = PIN_RD;
                            addr_nxt     = n_addr;
                            addr_nxt[10] = 1'b0;
                            ba_nxt       = n_ba;
                        end
                        3'd3: begin
                            pins_nxt     = PIN_WR;
                            addr_nxt     = n_addr;
                            addr_nxt[10] = 1'b0;
                            ba_nxt       = n_ba;
                        end
                        3'd4: begin
                            pins_nxt     = PIN_PRE;
                            addr_nxt     = n_addr;
                            addr_nxt[10] = 1'b0;
                            ba_nxt       = n_ba;
                            g_cnt_nxt    = GCNT_W'(TRP - 1);
                        end
                        3'd5: begin
                            pins_nxt     = PIN_PRE;
                            addr_nxt[10] = 1'b1;
                            g_cnt_nxt    = GCNT_W'(TRP - 1);
                        end
                        3'd6: begin
                            pins_nxt  = PIN_REF;
                            g_cnt_nxt = GCNT_W'(TRFC - 1);
                        end
                        3'd7: begin
                            pins_nxt  = PIN_LMR;
                            addr_nxt  = MR_VAL;
                            g_cnt_nxt = GCNT_W'(TMRD - 1);
                        end
                        default: ;
                    endcase
                end
                if (!i_ready)
                    state_nxt = ST_INI;
            end
            default: state_nxt = ST_INI;
        endcase
    end

    // Reset and sync clear both leave the pins deselected until the next clock.
    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            state                                      <= ST_INI;
            g_cnt                                      <= '0;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= PIN_DES;
            sdr_addr                                   <= '0;
            sdr_ba                                     <= '0;
            o_tviol                                    <= 1'b0;
        end else if (!mcb_sclr_n) begin
            state                                      <= ST_INI;
            g_cnt                                      <= '0;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= PIN_DES;
            sdr_addr                                   <= '0;
            sdr_ba                                     <= '0;
            o_tviol                                    <= 1'b0;
        end else begin
            state                                      <= state_nxt;
            g_cnt                                      <= g_cnt_nxt;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= pins_nxt;
            sdr_addr                                   <= addr_nxt;
            sdr_ba                                     <= ba_nxt;
            o_tviol                                    <= tviol_nxt;
        end
    end

endmodule

// File: tb/tb_mcb_cmd_enc.sv
// Directed bench for mcb_cmd_enc: expected pin tuples are queued when a cycle
// is driven and popped when the registered pins for that cycle appear.
module tb_mcb_cmd_enc;

    localparam logic [3:0] C_DES = 4'b1111;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  ba;
        logic        tv;
    } exp_t;

    logic        mcb_clk = 1'b0;
    logic        mcb_rst_n;
    logic        mcb_sclr_n;
    logic        i_prea, i_ref, i_lmr, i_ready;
    logic        n_cmd_vld;
    logic [2:0]  n_cmd;
    logic [11:0] n_addr;
    logic [1:0]  n_ba;
    logic        n_cmd_rdy;
    logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [11:0] sdr_addr;
    logic [1:0]  sdr_ba;
    logic        o_tviol;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    mcb_cmd_enc dut (
        .mcb_clk    (mcb_clk),
        .mcb_rst_n  (mcb_rst_n),
        .mcb_sclr_n (mcb_sclr_n),
        .i_prea     (i_prea),
        .i_ref      (i_ref),
        .i_lmr      (i_lmr),
        .i_ready    (i_ready),
        .n_cmd_vld  (n_cmd_vld),
        .n_cmd      (n_cmd),
        .n_addr     (n_addr),
        .n_ba       (n_ba),
        .n_cmd_rdy  (n_cmd_rdy),
        .sdr_cs_n   (sdr_cs_n),
        .sdr_ras_n  (sdr_ras_n),
        .sdr_cas_n  (sdr_cas_n),
        .sdr_we_n   (sdr_we_n),
        .sdr_addr   (sdr_addr),
        .sdr_ba     (sdr_ba),
        .o_tviol    (o_tviol)
    );

    always #5 mcb_clk = ~mcb_clk;

    task automatic checkOutput(input string tag, input exp_t e);
        exp_t obs;
        obs = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba, o_tviol};
        total++;
        assert (obs === e)
        else begin
            bad++;
            $error("[TB] FAIL %s pins: observed cmd=%b addr=%h ba=%0d tviol=%b expected cmd=%b addr=%h ba=%0d tviol=%b",
                   tag, obs.cmd, obs.addr, obs.ba, obs.tv, e.cmd, e.addr, e.ba, e.tv);
        end
    endtask

    task automatic checkRdy(input string tag, input logic erdy);
        total++;
        assert (n_cmd_rdy === erdy)
        else begin
            bad++;
            $error("[TB] FAIL %s rdy: observed=%b expected=%b", tag, n_cmd_rdy, erdy);
        end
    endtask

    // One clock cycle: drive, check ready, queue expected pins, clock, pop and compare.
    task automatic applyStimulus(input string tag, input logic [2:0] pulses, input logic rdy_in,
                                 input logic vld, input logic [2:0] cmd, input logic [11:0] addr,
                                 input logic [1:0] ba, input logic erdy, input logic [3:0] ecmd,
                                 input logic [11:0] eaddr, input logic [1:0] eba, input logic etv);
        exp_t e;
        {i_prea, i_ref, i_lmr} = pulses;
        i_ready   = rdy_in;
        n_cmd_vld = vld;
        n_cmd     = cmd;
        n_addr    = addr;
        n_ba      = ba;
        #1;
        checkRdy(tag, erdy);
        e = {ecmd, eaddr, eba, etv};
        sb_q.push_back(e);
        @(posedge mcb_clk);
        #1;
        {i_prea, i_ref, i_lmr} = 3'b000;
        n_cmd_vld = 1'b0;
        if (sb_q.size() != 0) begin
            checkOutput(tag, sb_q.pop_front());
        end else begin
            total++;
            bad++;
            $error("[TB] FAIL %s scoreboard: observed=empty expected=entry", tag);
        end
    endtask

    task automatic idle(input int n, input logic rdy_in, input logic erdy, input logic etv);
        for (int i = 0; i < n; i++)
            applyStimulus("idle", 3'b000, rdy_in, 1'b0, 3'd0, 12'h000, 2'd0,
                          erdy, C_NOP, 12'h000, 2'd0, etv);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mcb_rst_n  = 1'b0;
        mcb_sclr_n = 1'b1;
        {i_prea, i_ref, i_lmr, i_ready} = 4'b0000;
        n_cmd_vld = 1'b0;
        n_cmd     = 3'd0;
        n_addr    = 12'h000;
        n_ba      = 2'd0;
        repeat (2) @(posedge mcb_clk);
        #1;
        checkOutput("reset", {C_DES, 12'h000, 2'd0, 1'b0});
        checkRdy("reset", 1'b0);
        mcb_rst_n = 1'b1;

        $display("[TB] init sequence");
        idle(5, 1'b0, 1'b0, 1'b0);
        applyStimulus("prea", 3'b100, 0, 0, 0, 0, 0, 0, C_PRE, 12'h400, 2'd0, 0);
        idle(3, 1'b0, 1'b0, 1'b0);
        applyStimulus("ref1", 3'b010, 0, 0, 0, 0, 0, 0, C_REF, 12'h000, 2'd0, 0);
        idle(7, 1'b0, 1'b0, 1'b0);
        applyStimulus("ref2", 3'b010, 0, 0, 0, 0, 0, 0, C_REF, 12'h000, 2'd0, 0);
        idle(7, 1'b0, 1'b0, 1'b0);
        applyStimulus("lmr", 3'b001, 0, 0, 0, 0, 0, 0, C_LMR, 12'h032, 2'd0, 0);
        idle(2, 1'b0, 1'b0, 1'b0);

        $display("[TB] early refresh and sync clear");
        applyStimulus("ref_a", 3'b010, 0, 0, 0, 0, 0, 0, C_REF, 12'h000, 2'd0, 0);
        idle(2, 1'b0, 1'b0, 1'b0);
        applyStimulus("ref_early", 3'b010, 0, 0, 0, 0, 0, 0, C_REF, 12'h000, 2'd0, 1);
        idle(1, 1'b0, 1'b0, 1'b1);
        mcb_sclr_n = 1'b0;
        applyStimulus("sclr1", 3'b000, 0, 0, 0, 0, 0, 0, C_DES, 12'h000, 2'd0, 0);
        mcb_sclr_n = 1'b1;
        applyStimulus("go_run", 3'b000, 1, 0, 0, 0, 0, 0, C_NOP, 12'h000, 2'd0, 0);
        applyStimulus("run_idle", 3'b000, 1, 0, 0, 0, 0, 1, C_NOP, 12'h000, 2'd0, 0);
        applyStimulus("drop_wr", 3'b000, 0, 1, 3'd3, 12'h410, 2'd1, 1, C_WR, 12'h010, 2'd1, 0);
        applyStimulus("ini_again", 3'b000, 0, 0, 0, 0, 0, 0, C_NOP, 12'h000, 2'd0, 0);

        $display("[TB] simultaneous pulses");
        applyStimulus("multi", 3'b110, 0, 0, 0, 0, 0, 0, C_PRE, 12'h400, 2'd0, 1);
        idle(2, 1'b0, 1'b0, 1'b1);
        mcb_sclr_n = 1'b0;
        applyStimulus("sclr2", 3'b000, 0, 0, 0, 0, 0, 0, C_DES, 12'h000, 2'd0, 0);
        mcb_sclr_n = 1'b1;

        $display("[TB] normal path");
        applyStimulus("go_run2", 3'b000, 1, 0, 0, 0, 0, 0, C_NOP, 12'h000, 2'd0, 0);
        applyStimulus("act", 3'b000, 1, 1, 3'd1, 12'h155, 2'd2, 1, C_ACT, 12'h155, 2'd2, 0);
        applyStimulus("rd_wait1", 3'b000, 1, 1, 3'd2, 12'h010, 2'd2, 0, C_NOP, 12'h000, 2'd0, 0);
        applyStimulus("rd_wait2", 3'b000, 1, 1, 3'd2, 12'h010, 2'd2, 0, C_NOP, 12'h000, 2'd0, 0);
        applyStimulus("rd", 3'b000, 1, 1, 3'd2, 12'h010, 2'd2, 1, C_RD, 12'h010, 2'd2, 0);
        applyStimulus("wr1", 3'b000, 1, 1, 3'd3, 12'h7FF, 2'd1, 1, C_WR, 12'h3FF, 2'd1, 0);
        applyStimulus("wr2", 3'b000, 1, 1, 3'd3, 12'h123, 2'd3, 1, C_WR, 12'h123, 2'd3, 0);
        applyStimulus("pre", 3'b000, 1, 1, 3'd4, 12'h5A5, 2'd1, 1, C_PRE, 12'h1A5, 2'd1, 0);
        idle(2, 1'b1, 1'b0, 1'b0);
        applyStimulus("nop_cmd", 3'b000, 1, 1, 3'd0, 12'hABC, 2'd3, 1, C_NOP, 12'h000, 2'd0, 0);
        applyStimulus("prea_n", 3'b000, 1, 1, 3'd5, 12'h000, 2'd0, 1, C_PRE, 12'h400, 2'd0, 0);
        idle(2, 1'b1, 1'b0, 1'b0);
        applyStimulus("lmr_n", 3'b000, 1, 1, 3'd7, 12'h000, 2'd0, 1, C_LMR, 12'h032, 2'd0, 0);
        idle(1, 1'b1, 1'b0, 1'b0);
        applyStimulus("ref_n", 3'b000, 1, 1, 3'd6, 12'h000, 2'd0, 1, C_REF, 12'h000, 2'd0, 0);
        applyStimulus("pulse_run", 3'b100, 1, 1, 3'd1, 12'h055, 2'd1, 0, C_NOP, 12'h000, 2'd0, 1);

        $display("[TB] async reset");
        #3;
        mcb_rst_n = 1'b0;
        #1;
        checkOutput("async_rst", {C_DES, 12'h000, 2'd0, 1'b0});
        checkRdy("async_rst", 1'b0);
        @(posedge mcb_clk);
        #1;
        mcb_rst_n = 1'b1;

        total++;
        assert (sb_q.size() == 0)
        else begin
            bad++;
            $error("[TB] FAIL sb_drain: observed=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
